// File: rtl/piso_serializer_tx.sv
// LSB-first parallel-in/serial-out transmitter with busy/bitValid/done handshake.
// Pairs with the MSB-fed right-shifting receiver so the word reassembles in order.
module piso_serializer_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] parIn_i,
  input  logic             load_i,
  output logic             serOut_o,
  output logic             bitValid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] parOut_o
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE either chains straight into the next frame or drops back to IDLE
        if (load_i) begin
          shreg_d = parIn_i;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q == SHIFT);
  assign bitValid_o = (state_q == SHIFT);
  assign serOut_o   = (state_q == SHIFT) & shreg_q[0];
  assign done_o     = (state_q == DONE);
  assign parOut_o   = shreg_q;

endmodule

// File: tb/tb_piso_serializer_tx.sv
// Directed bench: vector table of frames on 4/8/16-bit instances plus hand sequences
// for reset mid-frame, load while busy, back-to-back frames and receiver loopback.
module tb_piso_serializer_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ld8 = 1'b0, ld4 = 1'b0, ld16 = 1'b0;
  logic [7:0]  p8 = '0;
  logic [3:0]  p4 = '0;
  logic [15:0] p16 = '0;
  logic        s8, v8, b8, d8, s4, v4, b4, d4, s16, v16, b16, d16;
  logic [7:0]  po8;
  logic [3:0]  po4;
  logic [15:0] po16;

  piso_serializer_tx #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .parIn_i(p8), .load_i(ld8), .serOut_o(s8),
    .bitValid_o(v8), .busy_o(b8), .done_o(d8), .parOut_o(po8));
  piso_serializer_tx #(.WIDTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .parIn_i(p4), .load_i(ld4), .serOut_o(s4),
    .bitValid_o(v4), .busy_o(b4), .done_o(d4), .parOut_o(po4));
  piso_serializer_tx #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .parIn_i(p16), .load_i(ld16), .serOut_o(s16),
    .bitValid_o(v16), .busy_o(b16), .done_o(d16), .parOut_o(po16));

  // Receiver: serIn into MSB, shift right, sampled on the falling edge
  logic [7:0] rx = '0;
  always @(negedge clk) if (v8) rx <= {s8, rx[7:1]};

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // {serOut, bitValid, busy, done}
  function automatic logic [3:0] st(input int sel);
    case (sel)
      0:       return {s8, v8, b8, d8};
      1:       return {s4, v4, b4, d4};
      default: return {s16, v16, b16, d16};
    endcase
  endfunction

  task automatic drive(input int sel, input logic l, input logic [15:0] w);
    case (sel)
      0:       begin ld8 = l;  p8 = w[7:0]; end
      1:       begin ld4 = l;  p4 = w[3:0]; end
      default: begin ld16 = l; p16 = w;     end
    endcase
  endtask

  // s lists the expected serOut bits in transmit order
  task automatic frame(input int sel, input int n, input logic [15:0] w, input string s,
                       input int busy_at);
    @(negedge clk); drive(sel, 1'b1, w);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == busy_at) drive(sel, 1'b1, 16'hFFFF);
      else              drive(sel, 1'b0, w);
      chk($sformatf("w%0d_bit%0d", n, i), st(sel), {s[i] == "1", 3'b110});
    end
    @(negedge clk); drive(sel, 1'b0, w);
    chk($sformatf("w%0d_done", n), st(sel), 4'b0001);
    @(negedge clk);
    chk($sformatf("w%0d_idle", n), st(sel), 4'b0000);
    if (sel == 0) chk("parOut_empty", po8, 0);
  endtask

  typedef struct {
    int          sel;
    int          n;
    logic [15:0] w;
    string       s;
  } vec_t;

  vec_t vec[5];

  initial begin
    string s1, s2;
    vec[0] = '{0, 8,  16'h00A5, "10100101"};
    vec[1] = '{0, 8,  16'h00FF, "11111111"};
    vec[2] = '{1, 4,  16'h0009, "1001"};
    vec[3] = '{2, 16, 16'h8001, "1000000000000001"};
    vec[4] = '{1, 4,  16'h0006, "0110"};

    // reset state, with a load pending: rst wins
    ld8 = 1'b1; p8 = 8'h5A;
    @(negedge clk);
    chk("rst_dut8", {st(0), po8}, 0);
    chk("rst_dut4", {st(1), po4}, 0);
    chk("rst_dut16", {st(2), po16}, 0);
    ld8 = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("post_rst", {st(0), po8}, 0);

    foreach (vec[k]) frame(vec[k].sel, vec[k].n, vec[k].w, vec[k].s, -1);

    // load while busy is dropped
    frame(0, 8, 16'h003C, "00111100", 4);

    // reset mid-frame
    @(negedge clk); drive(0, 1'b1, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 1'b0, 16'h00FF);
      chk($sformatf("rmf_bit%0d", i), st(0), 4'b1110);
    end
    #2 rst = 1'b1;
    #1 chk("rmf_async", {st(0), po8}, 0);
    drive(0, 1'b1, 16'h00AA);
    @(negedge clk);
    chk("rmf_held", {st(0), po8}, 0);
    drive(0, 1'b0, 16'h0000); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("rmf_quiet%0d", i), {st(0), po8}, 0);
    end
    frame(0, 8, 16'h0001, "10000000", -1);

    // back-to-back with load held high
    s1 = "11110000"; s2 = "00001111";
    @(negedge clk); drive(0, 1'b1, 16'h000F);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("b2b1_bit%0d", i), st(0), {s1[i] == "1", 3'b110});
    end
    @(negedge clk); drive(0, 1'b1, 16'h00F0);
    chk("b2b1_done", st(0), 4'b0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) drive(0, 1'b0, 16'h00F0);
      chk($sformatf("b2b2_bit%0d", i), st(0), {s2[i] == "1", 3'b110});
    end
    @(negedge clk);
    chk("b2b2_done", st(0), 4'b0001);
    @(negedge clk);
    chk("b2b_idle", st(0), 4'b0000);

    // loopback into receiver
    frame(0, 8, 16'h0096, "01101001", -1);
    chk("loopback_rx", rx, 8'h96);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
